// File: rtl/tank_pkg.sv
// tank_pkg: shared constants, one-hot direction encoding and bullet FSM states for the tank game.
package tank_pkg;
    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;
    localparam int TANK_SIZE   = 32;
    localparam int BULLET_SIZE = 8;
    localparam logic [9:0] PARK_POS = 10'h3FF;
    // Spawn = bullet centred on the tank, pushed out by half a tank plus half a bullet.
    localparam int SPAWN_CENTER = (TANK_SIZE - BULLET_SIZE) / 2;
    localparam int SPAWN_REACH  = (TANK_SIZE + BULLET_SIZE) / 2;
    typedef enum logic [1:0] {IDLE, FLIGHT, COOLDOWN} bullet_state_e;
    function automatic logic [3:0] lowest_dir(input logic [3:0] d);
        return d & (~d + 4'd1);
    endfunction
endpackage

// File: rtl/bullet_ctrl_if.sv
// bullet_ctrl_if: frame/tank inputs and bullet outputs of bullet_ctrl.
interface bullet_ctrl_if;
    logic       frame_tick;
    logic       fire;
    logic [9:0] tank_x;
    logic [9:0] tank_y;
    logic [3:0] tank_dir;
    logic       hit;
    logic [9:0] bullet_x;
    logic [9:0] bullet_y;
    logic [3:0] bullet_dir;
    logic       bullet_active;
    logic       fire_ack;
    modport master (
        output frame_tick, fire, tank_x, tank_y, tank_dir, hit,
        input  bullet_x, bullet_y, bullet_dir, bullet_active, fire_ack
    );
    modport slave (
        input  frame_tick, fire, tank_x, tank_y, tank_dir, hit,
        output bullet_x, bullet_y, bullet_dir, bullet_active, fire_ack
    );
endinterface

// File: rtl/bullet_step.sv
// bullet_step: moves an 8x8 box by i_amt along a direction and flags any part leaving the field.
module bullet_step
    import tank_pkg::*;
#(
    parameter int FIELD_W = 640,
    parameter int FIELD_H = 480
) (
    input  logic signed [10:0] i_x,
    input  logic signed [10:0] i_y,
    input  logic [3:0]         i_dir,
    input  logic [9:0]         i_amt,
    output logic [9:0]         o_x,
    output logic [9:0]         o_y,
    output logic               o_oob
);
    logic signed [11:0] w_x, w_y, w_amt, w_nx, w_ny;
    assign w_x   = 12'(i_x);
    assign w_y   = 12'(i_y);
    assign w_amt = 12'(i_amt);
    assign w_ny  = |(i_dir & DIR_UP)   ? w_y - w_amt :
                   |(i_dir & DIR_DOWN) ? w_y + w_amt : w_y;
    assign w_nx  = |(i_dir & (DIR_UP | DIR_DOWN)) ? w_x :
                   |(i_dir & DIR_LEFT)            ? w_x - w_amt :
                   |(i_dir & DIR_RIGHT)           ? w_x + w_amt : w_x;
    assign o_oob = w_nx[11] || w_ny[11] ||
                   int'(w_nx) + BULLET_SIZE > FIELD_W ||
                   int'(w_ny) + BULLET_SIZE > FIELD_H;
    assign o_x = w_nx[9:0];
    assign o_y = w_ny[9:0];
endmodule

// File: rtl/bullet_ctrl.sv
// bullet_ctrl: single-bullet FSM that spawns from the tank, flies per frame_tick and parks on end.
// Define BULLET_COOLDOWN_EN to hold COOLDOWN_FRAMES frame_ticks between bullet end and next fire.
module bullet_ctrl
    import tank_pkg::*;
#(
    parameter int SPEED           = 4,
    parameter int FIELD_W         = 640,
    parameter int FIELD_H         = 480,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic         vga_clk,
    input  logic         reset_n,
    bullet_ctrl_if.slave bus
);
    bullet_state_e      r_state, w_state;
    logic [9:0]         r_x, r_y, w_x, w_y, w_sx, w_sy;
    logic [3:0]         r_dir, w_dir, w_sdir;
    logic               r_active, w_active, r_ack, w_ack, w_idle, w_oob;
    logic signed [10:0] w_px, w_py;
`ifdef BULLET_COOLDOWN_EN
    localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
    logic [CW-1:0] r_cnt, w_cnt;
`endif
    assign w_idle = r_state == IDLE;
    assign w_sdir = lowest_dir(bus.tank_dir);
    // One mover serves both jobs: in IDLE it steps the tank-centred slot out to the spawn point.
    assign w_px = w_idle ? {1'b0, bus.tank_x} + 11'(SPAWN_CENTER) : {1'b0, r_x};
    assign w_py = w_idle ? {1'b0, bus.tank_y} + 11'(SPAWN_CENTER) : {1'b0, r_y};
    bullet_step #(.FIELD_W(FIELD_W), .FIELD_H(FIELD_H)) u_step (
        .i_x   (w_px),
        .i_y   (w_py),
        .i_dir (w_idle ? w_sdir : r_dir),
        .i_amt (w_idle ? 10'(SPAWN_REACH) : 10'(SPEED)),
        .o_x   (w_sx),
        .o_y   (w_sy),
        .o_oob (w_oob)
    );
    always_comb begin
        w_state  = r_state;
        w_x      = r_x;
        w_y      = r_y;
        w_dir    = r_dir;
        w_active = r_active;
        w_ack    = 1'b0;
`ifdef BULLET_COOLDOWN_EN
        w_cnt    = r_cnt;
`endif
        case (r_state)
            IDLE: if (bus.fire && w_sdir != 4'd0 && !w_oob) begin
                w_state  = FLIGHT;
                w_x      = w_sx;
                w_y      = w_sy;
                w_dir    = w_sdir;
                w_active = 1'b1;
                w_ack    = 1'b1;
            end
            FLIGHT: if (bus.hit || (bus.frame_tick && w_oob)) begin
                w_active = 1'b0;
                w_x      = PARK_POS;
                w_y      = PARK_POS;
`ifdef BULLET_COOLDOWN_EN
                w_state  = COOLDOWN;
                w_cnt    = '0;
`else
                w_state  = IDLE;
`endif
            end else if (bus.frame_tick) begin
                w_x = w_sx;
                w_y = w_sy;
            end
`ifdef BULLET_COOLDOWN_EN
            COOLDOWN: if (bus.frame_tick) begin
                w_cnt   = r_cnt == CW'(COOLDOWN_FRAMES - 1) ? '0 : r_cnt + 1'b1;
                w_state = r_cnt == CW'(COOLDOWN_FRAMES - 1) ? IDLE : COOLDOWN;
            end
`endif
            default: w_state = IDLE;
        endcase
    end
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_x      <= PARK_POS;
            r_y      <= PARK_POS;
            r_dir    <= DIR_UP;
            r_active <= 1'b0;
            r_ack    <= 1'b0;
`ifdef BULLET_COOLDOWN_EN
            r_cnt    <= '0;
`endif
        end else begin
            r_state  <= w_state;
            r_x      <= w_x;
            r_y      <= w_y;
            r_dir    <= w_dir;
            r_active <= w_active;
            r_ack    <= w_ack;
`ifdef BULLET_COOLDOWN_EN
            r_cnt    <= w_cnt;
`endif
        end
    end
    assign bus.bullet_x      = r_x;
    assign bus.bullet_y      = r_y;
    assign bus.bullet_dir    = r_dir;
    assign bus.bullet_active = r_active;
    assign bus.fire_ack      = r_ack;
endmodule

// File: tb/tb_bullet_ctrl.sv
// tb_bullet_ctrl: directed checks of bullet_ctrl spawn, flight, end, reset and (optional) cooldown.
module tb_bullet_ctrl;
    localparam int CF = 8;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    bullet_ctrl_if bus();
    bullet_ctrl #(.SPEED(4), .FIELD_W(640), .FIELD_H(480), .COOLDOWN_FRAMES(CF)) dut (
        .vga_clk (clk),
        .reset_n (rst_n),
        .bus     (bus.slave)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic check_bullet(input string tag, input logic [9:0] x, input logic [9:0] y,
                                input logic [3:0] d, input logic act);
        check({tag, "_x"}, 32'(bus.bullet_x), 32'(x));
        check({tag, "_y"}, 32'(bus.bullet_y), 32'(y));
        check({tag, "_dir"}, 32'(bus.bullet_dir), 32'(d));
        check({tag, "_active"}, 32'(bus.bullet_active), 32'(act));
    endtask
    task automatic drain();
`ifdef BULLET_COOLDOWN_EN
        for (int i = 0; i < CF; i++) begin
            bus.frame_tick = 1'b1;
            tick();
            bus.frame_tick = 1'b0;
            tick();
        end
`else
        tick();
`endif
    endtask
    task automatic set_tank(input logic [9:0] x, input logic [9:0] y, input logic [3:0] d);
        bus.tank_x   = x;
        bus.tank_y   = y;
        bus.tank_dir = d;
    endtask
    initial begin
        rst_n = 1'b0;
        bus.frame_tick = 1'b0;
        bus.fire = 1'b0;
        bus.hit = 1'b0;
        set_tank(10'd0, 10'd0, 4'b0000);
        tick();
        tick();
        check_bullet("reset", 10'h3FF, 10'h3FF, 4'b0001, 1'b0);
        check("reset_ack", 32'(bus.fire_ack), 32'd0);
        rst_n = 1'b1;
        // Up fire coinciding with frame_tick: spawn only, no movement
        set_tank(10'd100, 10'd100, 4'b0001);
        bus.fire = 1'b1;
        bus.frame_tick = 1'b1;
        tick();
        check("up_ack", 32'(bus.fire_ack), 32'd1);
        check_bullet("up_spawn", 10'd112, 10'd92, 4'b0001, 1'b1);
        bus.fire = 1'b0;
        bus.frame_tick = 1'b0;
        tick();
        check("up_ack_pulse", 32'(bus.fire_ack), 32'd0);
        bus.fire = 1'b1;
        tick();
        check("flight_fire_ignored", 32'(bus.fire_ack), 32'd0);
        check_bullet("flight_hold", 10'd112, 10'd92, 4'b0001, 1'b1);
        bus.fire = 1'b0;
        bus.hit = 1'b1;
        bus.frame_tick = 1'b1;
        tick();
        check_bullet("hit_tick_end", 10'h3FF, 10'h3FF, 4'b0001, 1'b0);
        bus.hit = 1'b0;
        bus.frame_tick = 1'b0;
        drain();
        // multi-hot direction: lowest bit (Down) wins
        set_tank(10'd300, 10'd200, 4'b1010);
        bus.fire = 1'b1;
        tick();
        check("multihot_ack", 32'(bus.fire_ack), 32'd1);
        check_bullet("multihot", 10'd312, 10'd232, 4'b0010, 1'b1);
        bus.fire = 1'b0;
        bus.hit = 1'b1;
        tick();
        bus.hit = 1'b0;
        drain();
        // Right, three frames of flight
        set_tank(10'd300, 10'd200, 4'b1000);
        bus.fire = 1'b1;
        tick();
        check_bullet("right_spawn", 10'd332, 10'd212, 4'b1000, 1'b1);
        bus.fire = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.frame_tick = 1'b1;
            tick();
            bus.frame_tick = 1'b0;
            if (i == 0) check("right_step1_x", 32'(bus.bullet_x), 32'd336);
            tick();
        end
        check_bullet("right_3frames", 10'd344, 10'd212, 4'b1000, 1'b1);
        bus.hit = 1'b1;
        tick();
        bus.hit = 1'b0;
        drain();
        // right edge: spawn flush with the border is legal, next step leaves the field
        set_tank(10'd600, 10'd200, 4'b1000);
        bus.fire = 1'b1;
        tick();
        check("edge_ack", 32'(bus.fire_ack), 32'd1);
        check_bullet("edge_spawn", 10'd632, 10'd212, 4'b1000, 1'b1);
        bus.fire = 1'b0;
        bus.frame_tick = 1'b1;
        tick();
        bus.frame_tick = 1'b0;
        check_bullet("edge_end", 10'h3FF, 10'h3FF, 4'b1000, 1'b0);
        drain();
        // out-of-bounds spawn and zero direction are both refused
        set_tank(10'd0, 10'd0, 4'b0100);
        bus.fire = 1'b1;
        tick();
        check("oob_spawn_ack", 32'(bus.fire_ack), 32'd0);
        check("oob_spawn_active", 32'(bus.bullet_active), 32'd0);
        set_tank(10'd100, 10'd100, 4'b0000);
        tick();
        check("nodir_ack", 32'(bus.fire_ack), 32'd0);
        check_bullet("idle_keeps", 10'h3FF, 10'h3FF, 4'b1000, 1'b0);
        bus.fire = 1'b0;
        // Up at y=2 leaves the field on the next frame
        set_tank(10'd100, 10'd10, 4'b0001);
        bus.fire = 1'b1;
        tick();
        check_bullet("top_spawn", 10'd112, 10'd2, 4'b0001, 1'b1);
        bus.fire = 1'b0;
        bus.frame_tick = 1'b1;
        tick();
        bus.frame_tick = 1'b0;
        check_bullet("top_end", 10'h3FF, 10'h3FF, 4'b0001, 1'b0);
        bus.fire = 1'b1;
`ifdef BULLET_COOLDOWN_EN
        for (int i = 0; i < CF; i++) begin
            bus.frame_tick = 1'b1;
            tick();
            bus.frame_tick = 1'b0;
            check("cooldown_no_ack", 32'(bus.fire_ack), 32'd0);
            if (i < CF - 1) begin
                tick();
                check("cooldown_no_ack", 32'(bus.fire_ack), 32'd0);
            end
        end
`endif
        tick();
        check("refire_ack", 32'(bus.fire_ack), 32'd1);
        check_bullet("refire", 10'd112, 10'd2, 4'b0001, 1'b1);
        bus.fire = 1'b0;
        bus.hit = 1'b1;
        tick();
        bus.hit = 1'b0;
        drain();
        // reset mid-flight parks at once and skips any cooldown
        set_tank(10'd100, 10'd100, 4'b0001);
        bus.fire = 1'b1;
        tick();
        check("pre_reset_ack", 32'(bus.fire_ack), 32'd1);
        bus.fire = 1'b0;
        tick();
        rst_n = 1'b0;
        bus.fire = 1'b1;
        bus.tank_dir = 4'b0010;
        tick();
        check_bullet("midflight_reset", 10'h3FF, 10'h3FF, 4'b0001, 1'b0);
        check("midflight_reset_ack", 32'(bus.fire_ack), 32'd0);
        rst_n = 1'b1;
        bus.hit = 1'b1;
        tick();
        check("post_reset_ack", 32'(bus.fire_ack), 32'd1);
        check_bullet("post_reset", 10'd112, 10'd132, 4'b0010, 1'b1);
        bus.fire = 1'b0;
        bus.hit = 1'b0;
        tick();
        check("post_reset_ack_pulse", 32'(bus.fire_ack), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bullet_ctrl.md
BULLET_CTRL -- requirements
Module: bullet_ctrl

Interface
REQ-001 SHALL have parameter SPEED, default 4, pixels moved per frame_tick.
REQ-002 SHALL have parameter FIELD_W, default 640, playfield width in pixels.
REQ-003 SHALL have parameter FIELD_H, default 480, playfield height in pixels.
REQ-004 SHALL have parameter COOLDOWN_FRAMES, default 8, frames between bullet end and next accepted fire.
REQ-005 SHALL have port vga_clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-007 SHALL have port frame_tick, input, 1, one-cycle pulse once per frame.
REQ-008 SHALL have port fire, input, 1, fire request, level.
REQ-009 SHALL have port tank_x and tank_y, input, 10 each, tank top-left; tank is 32x32.
REQ-010 SHALL have port tank_dir, input, 4, one-hot: bit0 Up, bit1 Down, bit2 Left, bit3 Right.
REQ-011 SHALL have port hit, input, 1, collision pulse from the renderer or game logic.
REQ-012 SHALL have port bullet_x and bullet_y, output, 10 each, bullet top-left; bullet is 8x8.
REQ-013 SHALL have port bullet_dir, output, 4, one-hot direction latched at fire.
REQ-014 SHALL have port bullet_active, output, 1, high while in flight.
REQ-015 SHALL have port fire_ack, output, 1, one-cycle pulse when a fire is accepted.

Function
REQ-016 SHALL implement the FSM states IDLE, FLIGHT and COOLDOWN; all outputs registered.
REQ-017 SHALL accept fire only in IDLE, with tank_dir nonzero and the spawn box inside the field; accept -> FLIGHT next cycle, fire_ack=1 for one cycle.
REQ-018 SHALL use lowest set tank_dir bit as priority when tank_dir is multi-hot; tank_dir=0 ignores fire.
REQ-019 SHALL spawn at: Up (tx+12, ty-8), Down (tx+12, ty+32), Left (tx-8, ty+12), Right (tx+32, ty+12).
REQ-020 SHALL compute spawn and step in 11-bit signed; negative result or x+8>FIELD_W or y+8>FIELD_H = out of bounds; out-of-bounds spawn -> fire ignored, no ack.
REQ-021 SHALL, in FLIGHT on frame_tick, move by SPEED in bullet_dir; if the next position is out of bounds, end the bullet rather than moving.
REQ-022 SHALL end the bullet on hit in FLIGHT; hit beats frame_tick in the same cycle; hit outside FLIGHT is ignored.
REQ-023 SHALL, on bullet end, drive bullet_active=0 and bullet_x=bullet_y=10'h3FF (park, never visible), go to COOLDOWN, and keep bullet_dir unchanged.
REQ-024 SHALL, when fire and frame_tick coincide in IDLE, spawn only, with no movement that cycle.
REQ-025 SHALL ignore fire in FLIGHT and COOLDOWN; a level held over the whole cooldown fires on the first IDLE cycle.

Reset
REQ-026 SHALL, on reset_n=0 at a clock edge: state IDLE, bullet_active=0, bullet_x=bullet_y=10'h3FF, bullet_dir=4'b0001, fire_ack=0, cooldown counter 0.
REQ-027 SHALL have reset override all inputs; reset mid-flight parks the bullet the next cycle, with no cooldown.

Configuration
REQ-028 SHALL, when BULLET_COOLDOWN_EN is defined, stay in COOLDOWN for COOLDOWN_FRAMES frame_ticks (counter 0..COOLDOWN_FRAMES-1), then go to IDLE.
REQ-029 SHALL, when BULLET_COOLDOWN_EN is undefined, omit COOLDOWN and its counter, and go from bullet end directly to IDLE the next cycle.

Structure
REQ-030 SHALL take from shared package tank_pkg: direction one-hot constants, TANK_SIZE=32, BULLET_SIZE=8, PARK_POS=10'h3FF, and the state enum.
REQ-031 SHALL use one combinational sub-module, bullet_step: inputs position, direction and step amount; outputs next position and out_of_bounds; used for both spawn and move.

Verification
REQ-032 SHALL verify: tank (100,100) Up, fire -> ack one cycle, bullet (112,92), dir 0001, active=1.
REQ-033 SHALL verify: tank (300,200) Right, fire, 3 frame_ticks -> bullet (344,212).
REQ-034 SHALL verify: bullet Up at y=2, frame_tick -> active=0, pos (3FF,3FF); with BULLET_COOLDOWN_EN, fire ignored for 8 frames, accepted after.
REQ-035 SHALL verify: tank (0,0) Left, fire -> no ack, stays IDLE.
REQ-036 SHALL verify: hit and frame_tick in the same cycle in FLIGHT -> bullet ends, position unchanged before park; fire during FLIGHT -> no ack.
REQ-037 SHALL verify: reset_n=0 mid-flight -> next cycle all REQ-026 values; fire after release -> immediate ack.
